// File: rtl/morse_decoder.sv
// Morse receiver: measures mark/space run lengths on en strobes, assembles
// dot/dash elements and emits the lowercase letter at each character gap.
module morse_decoder #(
    parameter int DASH_MIN = 3,
    parameter int GAP_MIN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    output logic [7:0] char,
    output logic       valid,
    output logic       err,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MARK  = 2'd1;
    localparam logic [1:0] SPACE = 2'd2;

    localparam logic [2:0] DASH_TH  = 3'(DASH_MIN);
    localparam logic [2:0] GAP_LAST = 3'(GAP_MIN - 1);

    logic [1:0] state;
    logic [2:0] run;
    logic [3:0] pat;
    logic [2:0] len;
    logic       ovf;
    logic [8:0] hit_ch;

    // Returns {hit, ascii}; the first element sent is the MSB of pat[len-1:0].
    function automatic logic [8:0] lookup(input logic [2:0] n, input logic [3:0] p);
        logic [7:0] c;
        c = 8'h00;
        case (n)
            3'd1: c = p[0] ? "t" : "e";
            3'd2: case (p[1:0])
                2'b01: c = "a";
                2'b10: c = "n";
                2'b00: c = "i";
                default: c = "m";
            endcase
            3'd3: case (p[2:0])
                3'b000: c = "s";
                3'b111: c = "o";
                3'b100: c = "d";
                3'b110: c = "g";
                3'b010: c = "r";
                3'b101: c = "k";
                3'b001: c = "u";
                default: c = "w";
            endcase
            3'd4: case (p)
                4'b0000: c = "h";
                4'b1000: c = "b";
                4'b1010: c = "c";
                4'b0010: c = "f";
                4'b0100: c = "l";
                4'b0110: c = "p";
                4'b1101: c = "q";
                4'b0001: c = "v";
                4'b1001: c = "x";
                4'b1011: c = "y";
                4'b1100: c = "z";
                4'b0111: c = "j";
                default: c = 8'h00;
            endcase
            default: c = 8'h00;
        endcase
        return {c != 8'h00, c};
    endfunction

    assign hit_ch = lookup(len, pat);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            run   <= 3'd0;
            pat   <= 4'd0;
            len   <= 3'd0;
            ovf   <= 1'b0;
            char  <= 8'h00;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (en) begin
                case (state)
                    IDLE: if (din) begin
                        state <= MARK;
                        run   <= 3'd1;
                        pat   <= 4'd0;
                        len   <= 3'd0;
                        ovf   <= 1'b0;
                    end
                    MARK: if (din) begin
                        if (run != 3'd7) run <= run + 3'd1;
                    end else begin
                        if (len < 3'd4) begin
                            pat <= {pat[2:0], (run >= DASH_TH)};
                            len <= len + 3'd1;
                        end else begin
                            ovf <= 1'b1;
                        end
                        state <= SPACE;
                        run   <= 3'd1;
                    end
                    SPACE: if (din) begin
                        state <= MARK;
                        run   <= 3'd1;
                    end else if (run < GAP_LAST) begin
                        run <= run + 3'd1;
                    end else begin
                        // End of character: decode on the GAP_MIN-th space.
                        if (hit_ch[8] && !ovf) begin
                            char  <= hit_ch[7:0];
                            valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= IDLE;
                        run   <= 3'd0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: expected letters/errors are queued as
// codes are keyed and matched against valid/err pulses as they appear.
module tb_morse_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       din = 1'b0;
    logic [7:0] char;
    logic       valid;
    logic       err;
    logic       busy;

    morse_decoder #(.DASH_MIN(3), .GAP_MIN(3)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .char(char), .valid(valid), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] ch;
    } exp_t;

    exp_t       q[$];
    logic [7:0] last_ch = 8'h00;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge, well away from the sampling edge.
    always @(negedge clk) begin
        if (!rst && (valid || err)) begin
            exp_t e;
            chk("excl", {31'd0, valid && err}, 32'd0);
            if (q.size() == 0) begin
                chk("unexp_out", {30'd0, valid, err}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("kind_err", {31'd0, err}, {31'd0, e.is_err});
                if (e.is_err) begin
                    chk("char_hold", {24'd0, char}, {24'd0, last_ch});
                end else begin
                    chk("char", {24'd0, char}, {24'd0, e.ch});
                    last_ch = e.ch;
                end
            end
        end
    end

    task automatic unit(input logic b);
        @(negedge clk);
        en  = 1'b1;
        din = b;
    endtask

    task automatic key(input string code, input logic e, input logic [7:0] c);
        exp_t x;
        x.is_err = e;
        x.ch     = c;
        q.push_back(x);
        for (int i = 0; i < code.len(); i++) begin
            if (code[i] == "-") begin
                unit(1'b1); unit(1'b1); unit(1'b1);
            end else begin
                unit(1'b1);
            end
            unit(1'b0);
        end
        unit(1'b0);
        unit(1'b0);
    endtask

    task automatic sparse(input logic b);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            en  = (k == 3);
            din = (k == 3) ? b : 1'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            en  = 1'b0;
            din = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] bits_a;
        exp_t       x;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_char",  {24'd0, char}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);

        // 'a' with explicit latency and busy checks (bit 0 sent first).
        bits_a = 8'b0001_1101;
        x.is_err = 1'b0;
        x.ch     = 8'h61;
        q.push_back(x);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("busy_on",  {31'd0, busy}, 32'd1);
                chk("no_early", {31'd0, valid}, 32'd0);
            end
            en  = 1'b1;
            din = bits_a[i];
        end
        @(negedge clk);
        en = 1'b0;
        chk("valid_lat", {31'd0, valid}, 32'd1);
        chk("busy_off",  {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("valid_1cyc", {31'd0, valid}, 32'd0);

        // Back-to-back 'z' then 'e', plus a few more letters.
        key("--..", 1'b0, 8'h7A);
        key(".",    1'b0, 8'h65);
        key("-.-.", 1'b0, 8'h63);
        key(".---", 1'b0, 8'h6A);
        key("--",   1'b0, 8'h6D);
        idle(2);

        // Overflow and undecodable four-element code.
        key(".....", 1'b1, 8'h00);
        key("..--",  1'b1, 8'h00);

        // Nine-unit mark saturates the counter and is still a dash.
        x.is_err = 1'b0;
        x.ch     = 8'h74;
        q.push_back(x);
        repeat (9) unit(1'b1);
        repeat (3) unit(1'b0);
        idle(2);

        // Strobe every 4th cycle with random off-strobe toggles: 'a'.
        x.ch = 8'h61;
        q.push_back(x);
        sparse(1'b1); sparse(1'b0);
        sparse(1'b1); sparse(1'b1); sparse(1'b1);
        sparse(1'b0); sparse(1'b0); sparse(1'b0);
        idle(3);

        // Reset mid-character discards the partial code.
        unit(1'b1); unit(1'b0); unit(1'b1); unit(1'b1); unit(1'b1);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_ch = 8'h00;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_char", {24'd0, char}, 32'd0);
        key(".", 1'b0, 8'h65);
        idle(5);

        chk("drain", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
